coffee_dispenser: RTL and testbench

- Downstream stage of the token/selection vending FSM. It consumes `dispense` and `coffee_select` and runs the physical dispense sequence: cup drop, cup detect, brew, flavour dose and drain.
- It returns a level `dispense_done` handshake to the vending FSM.
- It provides valve/actuator drives, a sticky fault and a served-cup counter.

---
 rtl/coffee_dispenser.sv | 198 +++++++++++++++++++
 tb/tb_coffee_dispenser.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/coffee_dispenser.sv
// Coffee dispenser sequencer: runs cup drop, cup detect, brew, optional
// flavour dose and drain for one request from the vending FSM, then
// acknowledges with a level dispense_done. Sticky fault on cup problems.
//
// state      | meaning
// -----------+--------------------------------------------------------
// S_IDLE     | waiting for dispense; latches coffee_select
// S_CHECK    | validates the latched selection
// S_CUP      | cup_drop held for CUP_CYCLES
// S_CUP_WAIT | waiting up to CUP_TIMEOUT cycles for cup_present
// S_BREW     | water_valve open for BREW_CYCLES
// S_FLAVOUR  | syrup valve open for FLAVOUR_CYCLES (sel 2/3 only)
// S_DRAIN    | all actuators off for DRAIN_CYCLES
// S_DONE     | dispense_done high until dispense drops
// S_FAULT    | sticky fault; dispense_done mirrors dispense
module coffee_dispenser #(
    parameter int CUP_CYCLES     = 4,
    parameter int CUP_TIMEOUT    = 16,
    parameter int BREW_CYCLES    = 20,
    parameter int FLAVOUR_CYCLES = 6,
    parameter int DRAIN_CYCLES   = 3,
    parameter int TW             = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dispense,
    input  logic [2:0]  coffee_select,
    input  logic        cup_present,
    output logic        dispense_done,
    output logic        cup_drop,
    output logic        water_valve,
    output logic [1:0]  flavour_valve,
    output logic        busy,
    output logic        fault,
    output logic        bad_select,
    output logic [15:0] cups_served
);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_CUP, S_CUP_WAIT, S_BREW,
        S_FLAVOUR, S_DRAIN, S_DONE, S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    sel_q, sel_d;
    logic          bad_select_q, bad_select_d;
    logic [15:0]   cups_served_q, cups_served_d;
    logic          dispense_done_q, dispense_done_d;
    logic          cup_drop_q, cup_drop_d;
    logic          water_valve_q, water_valve_d;
    logic [1:0]    flavour_valve_q, flavour_valve_d;
    logic          busy_q, busy_d;
    logic          fault_q, fault_d;

    logic          timer_last;
    logic [TW-1:0] timer_dec;

    assign timer_last = (timer_q == TW'(1));
    assign timer_dec  = timer_q - TW'(1);

    // Next-state, timer and bookkeeping; outputs derive from the next state
    // so every output is a flop that lines up with the state it belongs to.
    always_comb begin
        state_d         = state_q;
        timer_d         = timer_q;
        sel_d           = sel_q;
        bad_select_d    = bad_select_q;
        cups_served_d   = cups_served_q;

        case (state_q)
            S_IDLE: begin
                if (dispense) begin
                    sel_d   = coffee_select;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (sel_q >= 3'd1 && sel_q <= 3'd3) begin
                    state_d      = S_CUP;
                    timer_d      = TW'(CUP_CYCLES);
                    bad_select_d = 1'b0;
                end else begin
                    state_d      = S_DONE;
                    bad_select_d = 1'b1;
                end
            end
            S_CUP: begin
                if (timer_last) begin
                    state_d = S_CUP_WAIT;
                    timer_d = TW'(CUP_TIMEOUT);
                end else begin
                    timer_d = timer_dec;
                end
            end
            S_CUP_WAIT: begin
                if (cup_present) begin
                    state_d = S_BREW;
                    timer_d = TW'(BREW_CYCLES);
                end else if (timer_last) begin
                    state_d = S_FAULT;
                end else begin
                    timer_d = timer_dec;
                end
            end
            S_BREW: begin
                if (!cup_present) begin
                    state_d = S_FAULT;
                end else if (timer_last) begin
                    if (sel_q == 3'd1) begin
                        state_d = S_DRAIN;
                        timer_d = TW'(DRAIN_CYCLES);
                    end else begin
                        state_d = S_FLAVOUR;
                        timer_d = TW'(FLAVOUR_CYCLES);
                    end
                end else begin
                    timer_d = timer_dec;
                end
            end
            S_FLAVOUR: begin
                if (!cup_present) begin
                    state_d = S_FAULT;
                end else if (timer_last) begin
                    state_d = S_DRAIN;
                    timer_d = TW'(DRAIN_CYCLES);
                end else begin
                    timer_d = timer_dec;
                end
            end
            S_DRAIN: begin
                if (timer_last) begin
                    state_d       = S_DONE;
                    cups_served_d = cups_served_q + 16'd1;
                end else begin
                    timer_d = timer_dec;
                end
            end
            S_DONE: begin
                if (!dispense) state_d = S_IDLE;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cup_drop_d      = (state_d == S_CUP);
        water_valve_d   = (state_d == S_BREW);
        flavour_valve_d = 2'b00;
        if (state_d == S_FLAVOUR)
            flavour_valve_d = (sel_d == 3'd2) ? 2'b01 : 2'b10;
        busy_d          = (state_d != S_IDLE) && (state_d != S_FAULT);
        fault_d         = (state_d == S_FAULT);
        dispense_done_d = (state_d == S_DONE) || ((state_d == S_FAULT) && dispense);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            timer_q         <= '0;
            sel_q           <= '0;
            bad_select_q    <= 1'b0;
            cups_served_q   <= '0;
            dispense_done_q <= 1'b0;
            cup_drop_q      <= 1'b0;
            water_valve_q   <= 1'b0;
            flavour_valve_q <= 2'b00;
            busy_q          <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            sel_q           <= sel_d;
            bad_select_q    <= bad_select_d;
            cups_served_q   <= cups_served_d;
            dispense_done_q <= dispense_done_d;
            cup_drop_q      <= cup_drop_d;
            water_valve_q   <= water_valve_d;
            flavour_valve_q <= flavour_valve_d;
            busy_q          <= busy_d;
            fault_q         <= fault_d;
        end
    end

    assign dispense_done = dispense_done_q;
    assign cup_drop      = cup_drop_q;
    assign water_valve   = water_valve_q;
    assign flavour_valve = flavour_valve_q;
    assign busy          = busy_q;
    assign fault         = fault_q;
    assign bad_select    = bad_select_q;
    assign cups_served   = cups_served_q;

endmodule

// File: tb/tb_coffee_dispenser.sv
// Directed bench for coffee_dispenser: expectations are queued when a
// request is issued and popped as the DUT's observed results come back.
module tb_coffee_dispenser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dispense = 1'b0;
    logic [2:0]  coffee_select = 3'd0;
    logic        cup_present = 1'b0;
    logic        dispense_done;
    logic        cup_drop;
    logic        water_valve;
    logic [1:0]  flavour_valve;
    logic        busy;
    logic        fault;
    logic        bad_select;
    logic [15:0] cups_served;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;
    exp_t sb[$];

    coffee_dispenser dut (
        .clk(clk), .reset(reset), .dispense(dispense),
        .coffee_select(coffee_select), .cup_present(cup_present),
        .dispense_done(dispense_done), .cup_drop(cup_drop),
        .water_valve(water_valve), .flavour_valve(flavour_valve),
        .busy(busy), .fault(fault), .bad_select(bad_select),
        .cups_served(cups_served)
    );

    always #5 clk = ~clk;

    function automatic void push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endfunction

    task automatic check(input string tag, input int obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL %s: observed %0d, no expectation queued", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val && tag == e.tag) else begin
                miscompares++;
                $error("FAIL %s: observed %0d, expected %0d (%s)", tag, obs, e.val, e.tag);
            end
        end
    endtask

    function automatic int outs();
        return int'({cup_drop, water_valve, flavour_valve, busy, fault, bad_select, dispense_done});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a request and watch until dispense_done rises (or budget expires).
    task automatic run_req(input logic [2:0] sel, input int drop_cup_at,
                           output int lat, output int n_cup, output int n_wat,
                           output int n_flav, output int fcode,
                           output int bad, output int flt);
        lat = -1; n_cup = 0; n_wat = 0; n_flav = 0; fcode = 0; bad = 0; flt = 0;
        coffee_select = sel;
        dispense = 1'b1;
        for (int n = 0; n < 100; n++) begin
            step();
            if (cup_drop) n_cup++;
            if (water_valve) n_wat++;
            if (flavour_valve != 2'b00) begin
                n_flav++;
                fcode = fcode | int'(flavour_valve);
            end
            if (n == drop_cup_at) cup_present = 1'b0;
            if (dispense_done) begin
                lat = n;
                bad = int'(bad_select);
                flt = int'(fault);
                break;
            end
        end
    endtask

    task automatic check_req(input int lat, input int n_cup, input int n_wat,
                             input int n_flav, input int fcode,
                             input int bad, input int flt);
        check("latency", lat);
        check("cup_cycles", n_cup);
        check("water_cycles", n_wat);
        check("flavour_cycles", n_flav);
        check("flavour_code", fcode);
        check("bad_select", bad);
        check("fault", flt);
    endtask

    task automatic push_req(input int lat, input int n_cup, input int n_wat,
                            input int n_flav, input int fcode,
                            input int bad, input int flt);
        push("latency", lat);
        push("cup_cycles", n_cup);
        push("water_cycles", n_wat);
        push("flavour_cycles", n_flav);
        push("flavour_code", fcode);
        push("bad_select", bad);
        push("fault", flt);
    endtask

    task automatic release_req(input int exp_cups);
        push("done_after_release", 0);
        push("cups_served", exp_cups);
        dispense = 1'b0;
        step();
        check("done_after_release", int'(dispense_done));
        check("cups_served", int'(cups_served));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    int lat, n_cup, n_wat, n_flav, fcode, bad, flt, held;

    initial begin
        // Reset state
        push("reset_outputs", 0);
        push("reset_cups", 0);
        step();
        step();
        check("reset_outputs", outs());
        check("reset_cups", int'(cups_served));
        reset = 1'b0;
        cup_present = 1'b1;
        step();

        // Plain brew
        push_req(29, 4, 20, 0, 0, 0, 0);
        run_req(3'd1, -1, lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        check_req(lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        release_req(1);

        // Coconut then hazelnut back-to-back
        push_req(35, 4, 20, 6, 2, 0, 0);
        run_req(3'd3, -1, lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        check_req(lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        release_req(2);
        push_req(35, 4, 20, 6, 1, 0, 0);
        run_req(3'd2, -1, lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        check_req(lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        release_req(3);

        // Invalid select, then a valid request clears bad_select
        push_req(1, 0, 0, 0, 0, 1, 0);
        run_req(3'd0, -1, lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        check_req(lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        release_req(3);
        push_req(29, 4, 20, 0, 0, 0, 0);
        run_req(3'd1, -1, lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        check_req(lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        release_req(4);

        // Cup removed at brew cycle 10: water closes, fault, count unchanged
        push_req(16, 4, 10, 0, 0, 0, 1);
        run_req(3'd1, 15, lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        check_req(lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        push("water_after_removal", 0);
        check("water_after_removal", int'(water_valve));
        release_req(4);
        do_reset();

        // Cup timeout: no cup ever arrives
        cup_present = 1'b0;
        push_req(21, 4, 0, 0, 0, 0, 1);
        run_req(3'd1, -1, lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        check_req(lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        release_req(0);
        push("fault_done_follows", 1);
        push("fault_busy", 0);
        push("fault_cup_drop", 0);
        push("fault_sticky", 1);
        dispense = 1'b1;
        step();
        check("fault_done_follows", int'(dispense_done));
        step();
        step();
        check("fault_busy", int'(busy));
        check("fault_cup_drop", int'(cup_drop));
        check("fault_sticky", int'(fault));
        dispense = 1'b0;
        do_reset();
        cup_present = 1'b1;
        step();

        // Reset mid-FLAVOUR aborts immediately
        push("in_flavour", 2);
        push("abort_outputs", 0);
        push("abort_cups", 0);
        coffee_select = 3'd3;
        dispense = 1'b1;
        for (int n = 0; n <= 28; n++) step();
        check("in_flavour", int'(flavour_valve));
        reset = 1'b1;
        step();
        check("abort_outputs", outs());
        check("abort_cups", int'(cups_served));
        reset = 1'b0;
        dispense = 1'b0;
        step();

        // Dispense held in DONE for 10 cycles: done stays high
        push_req(29, 4, 20, 0, 0, 0, 0);
        run_req(3'd1, -1, lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        check_req(lat, n_cup, n_wat, n_flav, fcode, bad, flt);
        push("done_held_cycles", 10);
        held = 0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (dispense_done) held++;
        end
        check("done_held_cycles", held);
        release_req(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
